// File: rtl/execute_cc_stage.sv
// execute_cc_stage: execute-stage back end of the pipelined Y86-64 core.
// Computes ZF/SF/OF from the ALU operands/result, keeps them in the
// condition-code register, evaluates Cnd for jXX/cmovXX and latches the
// execute results into the E->M pipeline register (with stall/bubble).
module execute_cc_stage #(
  parameter int         DATA_W   = 64,
  parameter logic [3:0] REG_NONE = 4'hF,
  parameter logic [2:0] CC_RST   = 3'b100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              m_exc,
  input  logic              W_exc,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic              e_Cnd,
  output logic [3:0]        e_dstE,
  output logic [2:0]        cc_out,
  output logic [2:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);

  localparam logic [2:0] STAT_AOK  = 3'd1;
  localparam logic [3:0] ICODE_NOP = 4'd1;
  localparam logic [3:0] ICODE_CMOV = 4'd2;
  localparam logic [3:0] ICODE_OPQ = 4'd6;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;

  // Sign bits of the adder inputs and output; all sign tests use the MSB.
  logic sign_a, sign_b, sign_o;
  assign sign_a = alu_a[DATA_W-1];
  assign sign_b = alu_b[DATA_W-1];
  assign sign_o = alu_out[DATA_W-1];

  logic       new_zf, new_sf, new_of;
  logic       set_cc;
  logic [2:0] cc_q, cc_d;

  // New flags for the OPq in E; overflow only exists for add/sub (out = b OP a).
  always_comb begin
    new_zf = (alu_out == '0);
    new_sf = sign_o;
    new_of = 1'b0;
    case (E_ifun)
      ALU_ADD: new_of = (sign_a == sign_b) && (sign_o != sign_a);
      ALU_SUB: new_of = (sign_b != sign_a) && (sign_o != sign_b);
      default: new_of = 1'b0;
    endcase
  end

  // An exception further down the pipe must not let a younger OPq touch CC.
  assign set_cc = (E_icode == ICODE_OPQ) && !m_exc && !W_exc;

  // CC next state: load on set_cc, otherwise hold (independent of stall/bubble).
  always_comb begin
    cc_d = cc_q;
    if (set_cc) cc_d = {new_zf, new_sf, new_of};
  end

  // Condition-code register.
  always_ff @(posedge clk) begin
    if (!rst_n) cc_q <= CC_RST;
    else        cc_q <= cc_d;
  end

  assign cc_out = cc_q;

  logic zf, sf, of;
  assign zf = cc_q[2];
  assign sf = cc_q[1];
  assign of = cc_q[0];

  // Condition evaluation from the registered flags, selected by ifun.
  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      4'd0:    e_Cnd = 1'b1;
      4'd1:    e_Cnd = (sf ^ of) | zf;
      4'd2:    e_Cnd = sf ^ of;
      4'd3:    e_Cnd = zf;
      4'd4:    e_Cnd = ~zf;
      4'd5:    e_Cnd = ~(sf ^ of);
      4'd6:    e_Cnd = ~(sf ^ of) & ~zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  // A cmov whose condition fails writes nowhere.
  assign e_dstE = ((E_icode == ICODE_CMOV) && !e_Cnd) ? REG_NONE : E_dstE;

  logic [2:0]        stat_q, stat_d;
  logic [3:0]        icode_q, icode_d;
  logic              cnd_q, cnd_d;
  logic [DATA_W-1:0] vale_q, vale_d;
  logic [DATA_W-1:0] vala_q, vala_d;
  logic [3:0]        dste_q, dste_d;
  logic [3:0]        dstm_q, dstm_d;

  // E->M next state: bubble beats stall, stall holds, otherwise load from E.
  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    vale_d  = vale_q;
    vala_d  = vala_q;
    dste_d  = dste_q;
    dstm_d  = dstm_q;
    if (M_bubble) begin
      stat_d  = STAT_AOK;
      icode_d = ICODE_NOP;
      cnd_d   = 1'b0;
      vale_d  = '0;
      vala_d  = '0;
      dste_d  = REG_NONE;
      dstm_d  = REG_NONE;
    end else if (!M_stall) begin
      stat_d  = E_stat;
      icode_d = E_icode;
      cnd_d   = e_Cnd;
      vale_d  = alu_out;
      vala_d  = E_valA;
      dste_d  = e_dstE;
      dstm_d  = E_dstM;
    end
  end

  // E->M pipeline register; reset loads the same NOP as a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q  <= STAT_AOK;
      icode_q <= ICODE_NOP;
      cnd_q   <= 1'b0;
      vale_q  <= '0;
      vala_q  <= '0;
      dste_q  <= REG_NONE;
      dstm_q  <= REG_NONE;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      vale_q  <= vale_d;
      vala_q  <= vala_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
    end
  end

  assign M_stat  = stat_q;
  assign M_icode = icode_q;
  assign M_Cnd   = cnd_q;
  assign M_valE  = vale_q;
  assign M_valA  = vala_q;
  assign M_dstE  = dste_q;
  assign M_dstM  = dstm_q;

endmodule

// File: tb/tb_execute_cc_stage.sv
// tb_execute_cc_stage: scoreboard bench for execute_cc_stage.
module tb_execute_cc_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, alu_a, alu_b, alu_out;
  logic        m_exc, W_exc, M_stall, M_bubble;
  logic        e_Cnd;
  logic [3:0]  e_dstE;
  logic [2:0]  cc_out, M_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;

  execute_cc_stage dut (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .m_exc(m_exc), .W_exc(W_exc), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_Cnd(e_Cnd), .e_dstE(e_dstE), .cc_out(cc_out), .M_stat(M_stat), .M_icode(M_icode),
    .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } mrec_t;

  localparam mrec_t NOP_REC = '{stat: 3'd1, icode: 4'd1, cnd: 1'b0, vale: 64'd0,
                                vala: 64'd0, dste: 4'hF, dstm: 4'hF};

  mrec_t      exp_q[$];
  mrec_t      m_model;
  logic [2:0] cc_model;
  bit         model_valid = 0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference condition table; cc = {ZF,SF,OF}.
  function automatic logic cond_ref(input logic [2:0] cc, input logic [3:0] f);
    logic z, s, o;
    z = cc[2]; s = cc[1]; o = cc[0];
    case (f)
      4'd0: return 1'b1;
      4'd1: return (s != o) || z;
      4'd2: return s != o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return s == o;
      4'd6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Reference flags for an OPq: out = b OP a.
  function automatic logic [2:0] flags_ref(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] o, input logic [3:0] f);
    logic ovf;
    ovf = 1'b0;
    if (f == 4'd0) ovf = (a[63] & b[63] & ~o[63]) | (~a[63] & ~b[63] & o[63]);
    if (f == 4'd1) ovf = (b[63] & ~a[63] & ~o[63]) | (~b[63] & a[63] & o[63]);
    return {o == 64'd0, o[63], ovf};
  endfunction

  // One clock with the inputs currently driven: check the combinational
  // outputs, predict the E->M contents, clock, then compare.
  task automatic step(input string tag);
    logic  cnd_exp;
    logic [3:0] dst_exp;
    mrec_t got, want;
    #1;
    cnd_exp = cond_ref(cc_model, E_ifun);
    dst_exp = (E_icode == 4'd2 && !cnd_exp) ? 4'hF : E_dstE;
    if (model_valid && rst_n) begin
      check({tag, ".e_Cnd"}, 64'(e_Cnd), 64'(cnd_exp));
      check({tag, ".e_dstE"}, 64'(e_dstE), 64'(dst_exp));
    end
    if (!rst_n) begin
      cc_model = 3'b100;
      m_model  = NOP_REC;
    end else begin
      if (M_bubble) m_model = NOP_REC;
      else if (!M_stall)
        m_model = '{stat: E_stat, icode: E_icode, cnd: cnd_exp, vale: alu_out,
                    vala: E_valA, dste: dst_exp, dstm: E_dstM};
      if (E_icode == 4'd6 && !m_exc && !W_exc)
        cc_model = flags_ref(alu_a, alu_b, alu_out, E_ifun);
    end
    model_valid = 1;
    exp_q.push_back(m_model);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = '{stat: M_stat, icode: M_icode, cnd: M_Cnd, vale: M_valE, vala: M_valA,
             dste: M_dstE, dstm: M_dstM};
    check({tag, ".cc"}, 64'(cc_out), 64'(cc_model));
    check({tag, ".M_stat"}, 64'(got.stat), 64'(want.stat));
    check({tag, ".M_icode"}, 64'(got.icode), 64'(want.icode));
    check({tag, ".M_Cnd"}, 64'(got.cnd), 64'(want.cnd));
    check({tag, ".M_valE"}, got.vale, want.vale);
    check({tag, ".M_valA"}, got.vala, want.vala);
    check({tag, ".M_dstE"}, 64'(got.dste), 64'(want.dste));
    check({tag, ".M_dstM"}, 64'(got.dstm), 64'(want.dstm));
    $display("%-10s icode=%0d ifun=%0d cc=%b e_Cnd=%b M_icode=%0d M_dstE=%h",
             tag, E_icode, E_ifun, cc_out, e_Cnd, M_icode, M_dstE);
  endtask

  task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] o,
                       input logic [3:0] dste);
    E_icode = icode; E_ifun = ifun; alu_a = a; alu_b = b; alu_out = o; E_dstE = dste;
    E_valA  = a ^ 64'h1234; E_dstM = 4'd5; E_stat = 3'd1;
  endtask

  initial begin
    logic [63:0] ra, rb, ro;
    logic [3:0]  rf;
    rst_n = 1'b0; m_exc = 0; W_exc = 0; M_stall = 0; M_bubble = 0;
    set_e(4'd6, 4'd0, 64'd3, 64'd4, 64'd7, 4'd2);
    @(negedge clk);

    // 1: reset
    step("reset");
    check("rst.cc", 64'(cc_out), 64'(3'b100));
    check("rst.M_icode", 64'(M_icode), 64'd1);
    check("rst.M_dstE", 64'(M_dstE), 64'hF);
    check("rst.M_dstM", 64'(M_dstM), 64'hF);
    check("rst.M_Cnd", 64'(M_Cnd), 64'd0);
    rst_n = 1'b1;

    // 2: addq overflow into the sign bit, then jl
    set_e(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'd1);
    step("addq_ovf");
    check("t2.cc", 64'(cc_out), 64'(3'b011));
    set_e(4'd7, 4'd2, 64'd0, 64'd0, 64'd0, 4'hF);
    #1 check("t2.jl", 64'(e_Cnd), 64'd0);
    step("jl");

    // 3: subq equal operands, then cmovne squashed
    set_e(4'd6, 4'd1, 64'd5, 64'd5, 64'd0, 4'd4);
    step("subq_eq");
    check("t3.cc", 64'(cc_out), 64'(3'b100));
    set_e(4'd2, 4'd4, 64'd9, 64'd0, 64'd9, 4'd3);
    #1 check("t3.e_dstE", 64'(e_dstE), 64'hF);
    step("cmovne");
    check("t3.M_dstE", 64'(M_dstE), 64'hF);

    // 4: exceptions downstream block CC
    set_e(4'd6, 4'd0, 64'd1, 64'd1, 64'd2, 4'd2);
    m_exc = 1; step("opq_mexc");
    check("t4.m_hold", 64'(cc_out), 64'(3'b100));
    m_exc = 0; W_exc = 1; step("opq_wexc");
    check("t4.w_hold", 64'(cc_out), 64'(3'b100));
    W_exc = 0; E_stat = 3'd3; step("opq_ok");
    check("t4.upd", 64'(cc_out), 64'(3'b000));

    // 5: stall freezes M while CC keeps updating; bubble beats stall
    M_stall = 1;
    set_e(4'd6, 4'd3, 64'hF0, 64'hF0, 64'd0, 4'd6);
    step("stall1");
    set_e(4'd6, 4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 4'd7);
    step("stall2");
    check("t5.cc", 64'(cc_out), 64'(3'b010));
    M_bubble = 1; step("bub_stall");
    check("t5.bub", 64'(M_icode), 64'd1);
    M_stall = 0; M_bubble = 0;

    // 6: random add/sub followed by every condition; reset mid-sequence
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 3 == 0) rb = ra;
      rf = 4'($urandom_range(0, 1));
      ro = (rf == 4'd0) ? rb + ra : rb - ra;
      set_e(4'd6, rf, ra, rb, ro, 4'(i));
      if (i == 5) begin
        rst_n = 1'b0; step("rnd_rst"); rst_n = 1'b1;
        check("t6.rst_cc", 64'(cc_out), 64'(3'b100));
      end
      step("rnd_opq");
      for (int f = 0; f < 7; f++) begin
        set_e(4'd7, 4'(f), 64'd0, 64'd0, 64'd0, 4'hF);
        step("rnd_jxx");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
